// File: rtl/seu_pipe_if.sv
// rtl/seu_pipe_if.sv - decode-side request and ALU-side result handshake bundle for seu_pipe
interface seu_pipe_if #(
  parameter int IN_W      = 9,
  parameter int OUT_W     = 16,
  parameter int SHIFT_MAX = 3
);
  localparam int SH_W = (SHIFT_MAX > 0) ? $clog2(SHIFT_MAX + 1) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_nr;
  logic [1:0]       in_mode;
  logic [SH_W-1:0]  in_shamt;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_result;
  logic             out_neg;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_nr, in_mode, in_shamt, out_ready,
    output in_ready, out_valid, out_result, out_neg, out_ovf
  );

  modport master (
    output in_valid, in_nr, in_mode, in_shamt, out_ready,
    input  in_ready, out_valid, out_result, out_neg, out_ovf
  );
endinterface

// File: rtl/seu_pipe.sv
// rtl/seu_pipe.sv - registered sign/zero extension unit with a 2-entry result buffer
module seu_pipe #(
  parameter int IN_W      = 9,
  parameter int OUT_W     = 16,
  parameter int SHIFT_MAX = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  seu_pipe_if.slave bus
);
  localparam int TW = OUT_W + SHIFT_MAX;

  logic [1:0]       count;
  logic [OUT_W-1:0] res0, res1, new_res;
  logic             ovf0, ovf1, new_ovf;
  logic [TW-1:0]    sext, shifted;
  logic [31:0]      sh_amt;
  logic [SHIFT_MAX:0] top;
  logic             push, pop;

  // Result is computed once at push and stored, so the head stays stable under stall.
  always_comb begin
    sext   = {{(TW-IN_W){bus.in_nr[IN_W-1]}}, bus.in_nr};
    sh_amt = 32'(bus.in_shamt);
    if (sh_amt > 32'(SHIFT_MAX)) sh_amt = 32'(SHIFT_MAX);
    shifted = sext << sh_amt;
    top     = shifted[TW-1:OUT_W-1];
    new_res = '0;
    new_ovf = 1'b0;
    case (bus.in_mode)
      2'b00: new_res = {{(OUT_W-IN_W){1'b0}}, bus.in_nr};
      2'b01: new_res = sext[OUT_W-1:0];
      2'b10: begin
        new_res = shifted[OUT_W-1:0];
        new_ovf = !((&top) || !(|top));
      end
      default: ;
    endcase
  end

  assign push = bus.in_valid && (count != 2'd2);
  assign pop  = (count != 2'd0) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      res0  <= '0;
      res1  <= '0;
      ovf0  <= 1'b0;
      ovf1  <= 1'b0;
    end else begin
      case (count)
        2'd0: if (push) begin
          res0  <= new_res;
          ovf0  <= new_ovf;
          count <= 2'd1;
        end
        2'd1: if (push && pop) begin
          res0 <= new_res;
          ovf0 <= new_ovf;
        end else if (push) begin
          res1  <= new_res;
          ovf1  <= new_ovf;
          count <= 2'd2;
        end else if (pop) begin
          count <= 2'd0;
        end
        default: if (pop) begin
          res0  <= res1;
          ovf0  <= ovf1;
          count <= 2'd1;
        end
      endcase
    end
  end

  // Ready depends on occupancy alone, never on out_ready.
  assign bus.in_ready   = (count != 2'd2);
  assign bus.out_valid  = (count != 2'd0);
  assign bus.out_result = res0;
  assign bus.out_neg    = res0[OUT_W-1];
  assign bus.out_ovf    = ovf0;
endmodule
